multi_clock_divider: RTL and testbench

- Parametrised successor to the fixed two-output clock generator.
- Derives NUM_CH independent divided clocks from sysclk, each with:
  - a runtime-programmable divisor
  - a per-channel enable
  - a single-cycle tick strobe at each period start
- Divisor changes are glitch-free: shadowed and applied only at period boundaries.
- A global sync input phase-aligns all channels.
- Feeds display scanning, debouncing and slow-tick logic in the lab designs.

---
 rtl/multi_clock_divider_pkg.sv | 17 +
 rtl/multi_clock_divider_div_channel.sv | 108 ++++++++++
 rtl/multi_clock_divider.sv | 59 +++++
 tb/tb_multi_clock_divider.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_clock_divider_pkg.sv
// Shared definitions for the multi-channel clock divider.
//   DIV_MIN    smallest legal divisor; lower written values are raised to it
//   CH_IDX_W   width of the write-channel index bus
//   clamp_div  raises a requested divisor to DIV_MIN (divisors up to 32 bits)
package multi_clock_divider_pkg;

  localparam int DIV_MIN  = 2;
  localparam int CH_IDX_W = 3;

  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    if (d < 32'(DIV_MIN)) begin
      return 32'(DIV_MIN);
    end
    return d;
  endfunction

endpackage

// File: rtl/multi_clock_divider_div_channel.sv
// One divider channel: period counter, active/shadow divisor pair and
// registered clock/tick outputs.
// Ports:
//   i_clk      system clock, rising edge
//   i_rst_n    synchronous active-low reset
//   i_en       run enable (level); a 0->1 transition restarts at phase 0
//   i_wr       divisor write strobe already decoded for this channel
//   i_wr_div   new divisor, already clamped to >= DIV_MIN
//   i_sync     global restart strobe (acts only while enabled)
//   o_clk      divided clock, high for ceil(D/2) of every D cycles
//   o_tick     one-cycle pulse coinciding with each o_clk rising edge
//   o_pending  a written divisor is waiting for the next period boundary
module multi_clock_divider_div_channel #(
  parameter int DIV_W       = 27,
  parameter int DEFAULT_DIV = 100
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_wr_div,
  input  logic             i_sync,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_pending
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_active;
  logic [DIV_W-1:0] r_shadow;
  logic             r_pending;
  logic             r_en_d;
  logic             r_clk;
  logic             r_tick;

  logic             w_wrap;
  logic             w_restart;
  logic [DIV_W-1:0] w_cnt_run;
  logic [DIV_W-1:0] w_div_run;
  logic [DIV_W-1:0] w_hi_run;

  always_comb begin
    w_wrap    = (r_cnt == r_active - DIV_W'(1));
    w_cnt_run = w_wrap ? '0 : r_cnt + DIV_W'(1);
    // The high-time of the coming period uses the divisor that will be
    // active once this wrap has swapped in the shadow.
    w_div_run = (w_wrap && r_pending) ? r_shadow : r_active;
    w_hi_run  = w_div_run - (w_div_run >> 1);
    w_restart = i_en && (!r_en_d || i_sync);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_active  <= DIV_W'(DEFAULT_DIV);
      r_shadow  <= DIV_W'(DEFAULT_DIV);
      r_pending <= 1'b0;
      r_en_d    <= 1'b0;
      r_clk     <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_en_d <= i_en;
      if (!i_en) begin
        r_cnt  <= '0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
        // Idle channel: nothing to glitch, so a write takes effect at once.
        if (i_wr) begin
          r_active  <= i_wr_div;
          r_shadow  <= i_wr_div;
          r_pending <= 1'b0;
        end
      end else if (w_restart) begin
        // Phase 0: D >= 2 guarantees ceil(D/2) >= 1, so clock starts high.
        r_cnt  <= '0;
        r_clk  <= 1'b1;
        r_tick <= 1'b1;
        if (i_wr) begin
          r_active  <= i_wr_div;
          r_shadow  <= i_wr_div;
          r_pending <= 1'b0;
        end else if (r_pending) begin
          r_active  <= r_shadow;
          r_pending <= 1'b0;
        end
      end else begin
        r_cnt  <= w_cnt_run;
        r_clk  <= (w_cnt_run < w_hi_run);
        r_tick <= (w_cnt_run == '0);
        if (w_wrap && r_pending) begin
          r_active  <= r_shadow;
          r_pending <= 1'b0;
        end
        // A write landing on the wrap cycle is deferred: the wrap above
        // consumed the old shadow, this one waits for the next boundary.
        if (i_wr) begin
          r_shadow  <= i_wr_div;
          r_pending <= 1'b1;
        end
      end
    end
  end

  assign o_clk     = r_clk;
  assign o_tick    = r_tick;
  assign o_pending = r_pending;

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH independent programmable clock dividers running from sysclk.
// Ports:
//   sysclk    system clock, rising edge
//   rst       synchronous active-low reset
//   ch_en     per-channel run enable
//   wr_en     divisor write strobe (one cycle); wr_ch >= NUM_CH is ignored
//   wr_ch     target channel of the write
//   wr_div    new divisor; 0 and 1 are raised to 2
//   sync_all  one-cycle strobe restarting every enabled channel at phase 0
//   clk_out   divided clocks (registered)
//   tick      period-start strobes (registered)
//   pending   per-channel "shadow divisor not yet applied"
// Write interface: a write is taken on every rising edge where wr_en is 1;
// there is no back-pressure, the divider always accepts it.
module multi_clock_divider
  import multi_clock_divider_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 27,
  parameter int DEFAULT_DIV = 100
) (
  input  logic                sysclk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic                wr_en,
  input  logic [CH_IDX_W-1:0] wr_ch,
  input  logic [DIV_W-1:0]    wr_div,
  input  logic                sync_all,
  output logic [NUM_CH-1:0]   clk_out,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   pending
);

  logic [DIV_W-1:0]  w_wr_div_c;
  logic [NUM_CH-1:0] w_wr_hit;

  assign w_wr_div_c = DIV_W'(clamp_div(32'(wr_div)));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // Only indices 0..NUM_CH-1 can match, so out-of-range writes drop out.
    assign w_wr_hit[g] = wr_en && (wr_ch == CH_IDX_W'(g));

    multi_clock_divider_div_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .i_clk     (sysclk),
      .i_rst_n   (rst),
      .i_en      (ch_en[g]),
      .i_wr      (w_wr_hit[g]),
      .i_wr_div  (w_wr_div_c),
      .i_sync    (sync_all),
      .o_clk     (clk_out[g]),
      .o_tick    (tick[g]),
      .o_pending (pending[g])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
module tb_multi_clock_divider;

  localparam int NUM_CH = 2;
  localparam int DIV_W  = 27;

  // ---------------- clock / reset ----------------
  logic              sysclk = 1'b0;
  logic              rst = 1'b0;
  logic [NUM_CH-1:0] ch_en = '0;
  logic              wr_en = 1'b0;
  logic [2:0]        wr_ch = '0;
  logic [DIV_W-1:0]  wr_div = '0;
  logic              sync_all = 1'b0;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pending;

  always #5 sysclk = ~sysclk;

  multi_clock_divider #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(100)) dut (
    .sysclk   (sysclk),
    .rst      (rst),
    .ch_en    (ch_en),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_div   (wr_div),
    .sync_all (sync_all),
    .clk_out  (clk_out),
    .tick     (tick),
    .pending  (pending)
  );

  // ---------------- reference model ----------------
  // Each channel is described by its divisor and its age within the current
  // period; outputs follow from age: high while 2*age < D, tick at age 0.
  int m_d    [NUM_CH];
  int m_s    [NUM_CH];
  int m_age  [NUM_CH];
  bit m_pend [NUM_CH];
  bit m_on   [NUM_CH];
  bit m_clk  [NUM_CH];
  bit m_tick [NUM_CH];

  int compared   = 0;
  int mismatched = 0;

  function automatic int clampf(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      bit hit;
      int v;
      hit = wr_en && (int'(wr_ch) == c);
      v   = clampf(int'(wr_div));
      if (!rst) begin
        m_d[c] = 100; m_s[c] = 100; m_pend[c] = 0; m_on[c] = 0;
        m_age[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
      end else if (!ch_en[c]) begin
        if (hit) begin m_d[c] = v; m_s[c] = v; m_pend[c] = 0; end
        m_on[c] = 0; m_age[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
      end else begin
        if (!m_on[c] || sync_all) begin
          if (hit) begin m_d[c] = v; m_s[c] = v; m_pend[c] = 0; end
          else if (m_pend[c]) begin m_d[c] = m_s[c]; m_pend[c] = 0; end
          m_age[c] = 0;
        end else begin
          m_age[c]++;
          if (m_age[c] == m_d[c]) begin
            m_age[c] = 0;
            if (m_pend[c]) begin m_d[c] = m_s[c]; m_pend[c] = 0; end
          end
          if (hit) begin m_s[c] = v; m_pend[c] = 1; end
        end
        m_on[c]   = 1;
        m_clk[c]  = (2 * m_age[c] < m_d[c]);
        m_tick[c] = (m_age[c] == 0);
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag);
    logic [NUM_CH-1:0] e_clk, e_tick, e_pend;
    for (int c = 0; c < NUM_CH; c++) begin
      e_clk[c] = m_clk[c]; e_tick[c] = m_tick[c]; e_pend[c] = m_pend[c];
    end
    compared++;
    assert (clk_out === e_clk) else begin
      mismatched++;
      $error("FAIL %s clk_out t=%0t got=%b exp=%b", tag, $time, clk_out, e_clk);
    end
    compared++;
    assert (tick === e_tick) else begin
      mismatched++;
      $error("FAIL %s tick t=%0t got=%b exp=%b", tag, $time, tick, e_tick);
    end
    compared++;
    assert (pending === e_pend) else begin
      mismatched++;
      $error("FAIL %s pending t=%0t got=%b exp=%b", tag, $time, pending, e_pend);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input string tag);
    @(posedge sysclk);
    model_edge();
    #1;
    check(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic write_div(input int ch, input int d, input string tag);
    wr_en = 1'b1; wr_ch = 3'(ch); wr_div = DIV_W'(d);
    step(tag);
    wr_en = 1'b0;
  endtask

  // Step until channel ch reaches the given age; an expired budget is a failure.
  task automatic wait_age(input int ch, input int age, input string tag);
    bit found;
    found = (m_on[ch] && m_age[ch] == age);
    for (int k = 0; k < 400 && !found; k++) begin
      step(tag);
      found = (m_on[ch] && m_age[ch] == age);
    end
    compared++;
    assert (found) else begin
      mismatched++;
      $error("FAIL %s wait_age got=timeout exp=age%0d", tag, age);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    run(3, "reset");

    rst = 1'b1; ch_en = 2'b11;
    run(210, "default_d100");

    ch_en[0] = 1'b0;
    run(3, "disable");
    write_div(0, 5, "odd_write_idle");
    ch_en[0] = 1'b1;
    run(16, "odd_d5");

    wait_age(1, 30, "glitch_wait");
    write_div(1, 10, "glitch_write");
    run(100, "glitch_change");

    write_div(0, 0, "clamp_write");
    run(12, "clamp_d2");
    write_div(5, 9, "ignored_write");
    run(12, "ignored_ch");

    write_div(0, 7, "sync_setup0");
    write_div(1, 3, "sync_setup1");
    run(23, "sync_pre");
    sync_all = 1'b1;
    step("sync_pulse");
    sync_all = 1'b0;
    run(30, "sync_post");

    write_div(1, 4, "collide_pre");
    wait_age(1, 1, "collide_wait");
    // Land a second write on the wrap edge of the period now in progress.
    for (int k = 0; k < 20 && m_age[1] != m_d[1] - 1; k++) step("collide_align");
    write_div(1, 6, "collide_write");
    run(20, "collide_post");

    write_div(0, 9, "sync_write");
    wr_en = 1'b1; wr_ch = 3'd0; wr_div = DIV_W'(5); sync_all = 1'b1;
    step("sync_plus_write");
    wr_en = 1'b0; sync_all = 1'b0;
    run(12, "sync_plus_write_post");

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) ch_en = 2'($urandom_range(0, 3));
      wr_en    = ($urandom_range(0, 9) == 0);
      wr_ch    = 3'($urandom_range(0, 7) < 6 ? $urandom_range(0, 1) : $urandom_range(2, 7));
      wr_div   = DIV_W'($urandom_range(0, 12));
      sync_all = ($urandom_range(0, 39) == 0);
      step("random");
    end
    wr_en = 1'b0; sync_all = 1'b0; ch_en = 2'b11;
    run(30, "random_settle");

    write_div(0, 6, "reset_midrun_write");
    rst = 1'b0;
    step("reset_midrun");
    rst = 1'b1;
    run(110, "after_reset_d100");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
